bit_collect: RTL and testbench

- Receive end of the ASCII bit-stream path: consumes one character per cycle, each '0' (8'h30) or '1' (8'h31).
- Assembles WIDTH accepted bits into a word.
- Presents both the word as received and its bit-reversed form to the downstream bit-reversal/display logic over a valid/ready handshake.
- Flags and drops illegal characters, and counts completed words.

---
 rtl/bit_pkg.sv | 23 ++
 rtl/bit_reverse.sv | 19 +
 rtl/bit_collect.sv | 113 +++++++++++
 tb/tb_bit_collect.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/bit_pkg.sv
// bit_pkg: constants shared by both ends of the ASCII bit-stream path.
//   ASCII_ZERO / ASCII_ONE : character codes that carry a bit value.
//   ST_COLLECT / ST_HOLD   : state encoding of the receive FSM.
//   state_e                : enum built on that encoding.
//   is_bit_char()          : true for the two legal bit characters.
package bit_pkg;

   localparam logic [7:0] ASCII_ZERO = 8'h30;
   localparam logic [7:0] ASCII_ONE  = 8'h31;

   localparam logic ST_COLLECT = 1'b0;
   localparam logic ST_HOLD    = 1'b1;

   typedef enum logic {
      S_COLLECT = ST_COLLECT,
      S_HOLD    = ST_HOLD
   } state_e;

   function automatic logic is_bit_char(input logic [7:0] c);
      return (c == ASCII_ZERO) || (c == ASCII_ONE);
   endfunction

endpackage

// File: rtl/bit_reverse.sv
// bit_reverse: purely combinational bit-order reversal.
//   in_bits  [WIDTH-1:0] : input vector
//   out_bits [WIDTH-1:0] : out_bits[i] = in_bits[WIDTH-1-i]
// Shared with the downstream reversal stage.
module bit_reverse #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] in_bits,
   output logic [WIDTH-1:0] out_bits
);

   always_comb begin
      out_bits = '0;
      for (int i = 0; i < WIDTH; i++) begin
         out_bits[i] = in_bits[WIDTH-1-i];
      end
   end

endmodule

// File: rtl/bit_collect.sv
// bit_collect: receive end of the ASCII bit-stream path.
// Collects WIDTH '0'/'1' characters into a word (first bit in MSB) and
// offers the word plus its bit-reversal downstream over valid/ready.
// Illegal characters are consumed, dropped and flagged with err.
//   clk        : clock, rising edge
//   reset      : asynchronous, active-high
//   char_in    : ASCII character from the bit source
//   char_valid : char_in holds a character
//   char_ready : character accepted this cycle
//   word_out   : assembled word
//   word_rev   : bit-reverse of word_out
//   word_valid : word_out/word_rev hold a complete word
//   word_ready : downstream takes the word
//   bit_count  : bits accepted in the word being collected
//   err        : one-cycle pulse per discarded illegal character
//   word_total : completed handshakes since reset, wraps at 256
module bit_collect
   import bit_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [7:0]       char_in,
   input  logic             char_valid,
   output logic             char_ready,
   output logic [WIDTH-1:0] word_out,
   output logic [WIDTH-1:0] word_rev,
   output logic             word_valid,
   input  logic             word_ready,
   output logic [CNT_W-1:0] bit_count,
   output logic             err,
   output logic [7:0]       word_total
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [WIDTH-1:0] word_q, word_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       total_q, total_d;
   logic             err_q, err_d;

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      word_d  = word_q;
      cnt_d   = cnt_q;
      total_d = total_q;
      err_d   = 1'b0;
      case (state_q)
         S_COLLECT: begin
            if (char_valid) begin
               if (is_bit_char(char_in)) begin
                  // New bit enters at the LSB so the first bit ends up in the MSB.
                  shift_d = {shift_q[WIDTH-2:0], (char_in == ASCII_ONE)};
                  if (cnt_q == LAST_CNT) begin
                     state_d = S_HOLD;
                     cnt_d   = '0;
                     word_d  = shift_d;
                  end else begin
                     cnt_d = cnt_q + 1'b1;
                  end
               end else begin
                  // Illegal character: consumed, no effect on the word being built.
                  err_d = 1'b1;
               end
            end
         end
         S_HOLD: begin
            if (word_ready) begin
               state_d = S_COLLECT;
               total_d = total_q + 8'd1;
            end
         end
         default: state_d = S_COLLECT;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_COLLECT;
         shift_q <= '0;
         word_q  <= '0;
         cnt_q   <= '0;
         total_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         word_q  <= word_d;
         cnt_q   <= cnt_d;
         total_q <= total_d;
         err_q   <= err_d;
      end
   end

   // Gated by reset so the source sees no acceptance while reset is held.
   assign char_ready = (state_q == S_COLLECT) && !reset;
   assign word_valid = (state_q == S_HOLD);
   assign word_out   = word_q;
   assign bit_count  = cnt_q;
   assign err        = err_q;
   assign word_total = total_q;

   bit_reverse #(.WIDTH(WIDTH)) u_rev (
      .in_bits  (word_q),
      .out_bits (word_rev)
   );

endmodule

// File: tb/tb_bit_collect.sv
// tb_bit_collect: scoreboard bench for bit_collect (WIDTH=8).
module tb_bit_collect;
   import bit_pkg::*;

   localparam int W  = 8;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [7:0]    char_in = 8'h00;
   logic          char_valid = 1'b0;
   logic          char_ready;
   logic [W-1:0]  word_out;
   logic [W-1:0]  word_rev;
   logic          word_valid;
   logic          word_ready = 1'b0;
   logic [CW-1:0] bit_count;
   logic          err;
   logic [7:0]    word_total;

   always #5 clk = ~clk;

   bit_collect #(.WIDTH(W), .CNT_W(CW)) dut (
      .clk        (clk),
      .reset      (reset),
      .char_in    (char_in),
      .char_valid (char_valid),
      .char_ready (char_ready),
      .word_out   (word_out),
      .word_rev   (word_rev),
      .word_valid (word_valid),
      .word_ready (word_ready),
      .bit_count  (bit_count),
      .err        (err),
      .word_total (word_total)
   );

   typedef struct {
      logic [W-1:0] word;
      logic [W-1:0] rev;
   } exp_t;

   exp_t sb[$];

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   // Reference model of the receiver
   logic [W-1:0] m_shift = '0;
   logic [W-1:0] m_word  = '0;
   int           m_cnt   = 0;
   logic         m_hold  = 1'b0;
   logic         m_err   = 1'b0;
   logic [7:0]   m_total = 8'd0;

   int unsigned cyc = 0;
   int unsigned last_hs = 0;
   logic        have_last = 1'b0;
   logic        tp_mode = 1'b0;

   always @(posedge clk) cyc++;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] rev_of(input logic [W-1:0] v);
      logic [W-1:0] r;
      for (int i = 0; i < W; i++) r[i] = v[W-1-i];
      return r;
   endfunction

   // Handshake monitor: pop the scoreboard when the DUT hands a word over.
   always @(negedge clk) begin
      if (!reset && word_valid && word_ready) begin
         chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
         if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("word_out", 32'(word_out), 32'(e.word));
            chk("word_rev", 32'(word_rev), 32'(e.rev));
         end
         if (tp_mode) begin
            if (have_last) chk("spacing", cyc - last_hs, 32'd9);
            last_hs   = cyc;
            have_last = 1'b1;
         end
      end
   end

   // Drive one cycle of stimulus, advance the model, then check after the edge.
   task automatic step(input logic [7:0] c, input logic v, input logic rdy);
      char_in    = c;
      char_valid = v;
      word_ready = rdy;
      m_err      = 1'b0;
      if (!m_hold) begin
         if (v) begin
            if (c == ASCII_ZERO || c == ASCII_ONE) begin
               m_shift = {m_shift[W-2:0], (c == ASCII_ONE)};
               m_cnt++;
               if (m_cnt == W) begin
                  exp_t e;
                  m_cnt  = 0;
                  m_hold = 1'b1;
                  m_word = m_shift;
                  e.word = m_shift;
                  e.rev  = rev_of(m_shift);
                  sb.push_back(e);
               end
            end else begin
               m_err = 1'b1;
            end
         end
      end else if (rdy) begin
         m_hold  = 1'b0;
         m_total = m_total + 8'd1;
      end
      @(posedge clk);
      #1;
      chk("word_valid", 32'(word_valid), 32'(m_hold));
      chk("char_ready", 32'(char_ready), 32'(!m_hold));
      chk("bit_count", 32'(bit_count), 32'(m_cnt));
      chk("err", 32'(err), 32'(m_err));
      chk("word_total", 32'(word_total), 32'(m_total));
      if (m_hold) begin
         chk("hold_word", 32'(word_out), 32'(m_word));
         chk("hold_rev", 32'(word_rev), 32'(rev_of(m_word)));
      end
   endtask

   task automatic send_bits(input logic [W-1:0] v, input logic rdy);
      for (int i = W - 1; i >= 0; i--) step(v[i] ? ASCII_ONE : ASCII_ZERO, 1'b1, rdy);
   endtask

   task automatic do_reset();
      char_valid = 1'b0;
      reset      = 1'b1;
      m_shift = '0; m_word = '0; m_cnt = 0; m_hold = 1'b0; m_err = 1'b0; m_total = 8'd0;
      sb.delete();
      #1;
      chk("rst_char_ready", 32'(char_ready), 32'd0);
      chk("rst_word_valid", 32'(word_valid), 32'd0);
      chk("rst_word_out", 32'(word_out), 32'd0);
      chk("rst_word_rev", 32'(word_rev), 32'd0);
      chk("rst_bit_count", 32'(bit_count), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_word_total", 32'(word_total), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      chk("rel_char_ready", 32'(char_ready), 32'd1);
   endtask

   initial begin
      #1;
      do_reset();

      // F0 with downstream always ready
      send_bits(8'hF0, 1'b1);
      step(ASCII_ZERO, 1'b0, 1'b1);
      chk("total_after_f0", 32'(word_total), 32'd1);

      // B2 held for 5 cycles with chars offered and ignored, then taken
      send_bits(8'hB2, 1'b0);
      for (int i = 0; i < 5; i++) step(ASCII_ONE, 1'b1, 1'b0);
      step(ASCII_ONE, 1'b0, 1'b1);
      step(ASCII_ONE, 1'b0, 1'b0);

      // Illegal 'x' after the third bit
      step(ASCII_ONE, 1'b1, 1'b1);
      step(ASCII_ONE, 1'b1, 1'b1);
      step(ASCII_ONE, 1'b1, 1'b1);
      step(8'h78, 1'b1, 1'b1);
      chk("err_cnt_held", 32'(bit_count), 32'd3);
      step(ASCII_ONE, 1'b1, 1'b1);
      for (int i = 0; i < 4; i++) step(ASCII_ZERO, 1'b1, 1'b1);
      step(ASCII_ZERO, 1'b0, 1'b1);

      // Reset after 5 bits, then a fresh all-zero word
      for (int i = 0; i < 5; i++) step(ASCII_ONE, 1'b1, 1'b1);
      do_reset();
      send_bits(8'h00, 1'b1);
      step(ASCII_ZERO, 1'b0, 1'b1);
      chk("total_after_00", 32'(word_total), 32'd1);

      // Reset while holding a word drops word_valid at once
      send_bits(8'h5A, 1'b0);
      do_reset();

      // Toggle char_valid while sending 10101010
      for (int i = 0; i < W; i++) begin
         step((i % 2 == 0) ? ASCII_ONE : ASCII_ZERO, 1'b1, 1'b1);
         if (i != W - 1) step((i % 2 == 0) ? ASCII_ONE : 8'h78, 1'b0, 1'b1);
      end
      chk("aa_word", 32'(word_out), 32'hAA);
      chk("aa_rev", 32'(word_rev), 32'h55);
      step(ASCII_ZERO, 1'b0, 1'b1);

      // 256 back-to-back words: total wraps and spacing is WIDTH+1 cycles
      do_reset();
      tp_mode   = 1'b1;
      have_last = 1'b0;
      for (int w = 0; w < 256; w++) begin
         send_bits(W'($urandom), 1'b1);
         step(ASCII_ONE, 1'b1, 1'b1);
      end
      tp_mode = 1'b0;
      chk("total_wrap", 32'(word_total), 32'd0);

      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout tests=%0d", n_tests);
      $fatal(1, "timeout");
   end

endmodule
